// File: rtl/z80_alu_shifter.sv
// z80_alu_shifter: registered 8-bit single-position shifter feeding the Z80 ALU nibble buses.
// Defining ALU_SHIFTER_PARITY_EN adds a registered even-parity output (parity_out).
module z80_alu_shifter (
    input  logic       clk,
    input  logic       nreset,
    input  logic       shift_enable,
    input  logic       shift_right,
    input  logic       shift_in,
    input  logic [7:0] db,
    output logic       cy_out,
    output logic [3:0] out_high,
    output logic [3:0] out_low
`ifdef ALU_SHIFTER_PARITY_EN
    ,
    output logic       parity_out
`endif
);
    logic [7:0] r_d, r_q;
    logic       c_d, c_q;
    always_comb begin
        r_d = shift_enable ? (shift_right ? {shift_in, db[7:1]} : {db[6:0], shift_in}) : db;
        c_d = shift_enable & (shift_right ? db[0] : db[7]);
    end
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_q <= 8'h00;
            c_q <= 1'b0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end
    assign out_high = r_q[7:4];
    assign out_low  = r_q[3:0];
    assign cy_out   = c_q;
`ifdef ALU_SHIFTER_PARITY_EN
    // Z80 P/V convention: set for an even number of ones, so the cleared result resets to 1.
    logic p_d, p_q;
    assign p_d = ~^r_d;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) p_q <= 1'b1;
        else         p_q <= p_d;
    end
    assign parity_out = p_q;
`endif
endmodule

// File: tb/tb_z80_alu_shifter.sv
// tb_z80_alu_shifter: directed self-checking bench for z80_alu_shifter.
// Parity checks are included when ALU_SHIFTER_PARITY_EN is defined.
module tb_z80_alu_shifter;
    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       shift_enable = 1'b0;
    logic       shift_right = 1'b0;
    logic       shift_in = 1'b0;
    logic [7:0] db = 8'h00;
    logic       cy_out;
    logic [3:0] out_high, out_low;
    int         n_assert = 0;
    int         n_fail = 0;
`ifdef ALU_SHIFTER_PARITY_EN
    logic       parity_out;
`endif

    z80_alu_shifter dut (
        .clk(clk),
        .nreset(nreset),
        .shift_enable(shift_enable),
        .shift_right(shift_right),
        .shift_in(shift_in),
        .db(db),
        .cy_out(cy_out),
        .out_high(out_high),
        .out_low(out_low)
`ifdef ALU_SHIFTER_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic exp_c, input logic [7:0] exp_r);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {cy_out, out_high, out_low};
        exp = {exp_c, exp_r};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed cy=%b r=%h, expected cy=%b r=%h", tag, obs[8], obs[7:0], exp[8], exp[7:0]);
        end
    endtask

`ifdef ALU_SHIFTER_PARITY_EN
    task automatic chk_p(input string tag, input logic exp_p);
        n_assert++;
        assert (parity_out === exp_p) else begin
            n_fail++;
            $error("FAIL %s: observed parity=%b, expected parity=%b", tag, parity_out, exp_p);
        end
    endtask
`endif

    task automatic drive(input logic se, input logic sr, input logic si, input logic [7:0] d);
        shift_enable = se;
        shift_right  = sr;
        shift_in     = si;
        db           = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset clears immediately, before any clock edge, and holds
        drive(1'b1, 1'b0, 1'b1, 8'hFF);
        #1 nreset = 1'b0;
        #1 chk("reset_async", 1'b0, 8'h00);
`ifdef ALU_SHIFTER_PARITY_EN
        chk_p("reset_parity", 1'b1);
`endif
        repeat (3) tick();
        chk("reset_hold", 1'b0, 8'h00);
        @(negedge clk);
        nreset = 1'b1;
        // Pass-through ignores shift_in
        drive(1'b0, 1'b0, 1'b1, 8'hA5);
        tick();
        chk("pass_a5", 1'b0, 8'hA5);
        drive(1'b1, 1'b0, 1'b0, 8'h81);
        tick();
        chk("left_81_si0", 1'b1, 8'h02);
        drive(1'b1, 1'b0, 1'b1, 8'h81);
        tick();
        chk("left_81_si1", 1'b1, 8'h03);
        drive(1'b1, 1'b1, 1'b1, 8'h81);
        tick();
        chk("right_81_si1", 1'b1, 8'hC0);
        drive(1'b1, 1'b1, 1'b0, 8'h02);
        tick();
        chk("right_02_si0", 1'b0, 8'h01);
        // Back-to-back across the modes
        drive(1'b0, 1'b1, 1'b1, 8'h3C);
        tick();
        chk("b2b_pass_3c", 1'b0, 8'h3C);
        drive(1'b1, 1'b0, 1'b1, 8'h3C);
        tick();
        chk("b2b_left_3c", 1'b0, 8'h79);
        drive(1'b1, 1'b1, 1'b1, 8'h3C);
        tick();
        chk("b2b_right_3c", 1'b0, 8'h9E);
        drive(1'b1, 1'b0, 1'b0, 8'hC3);
        tick();
        chk("b2b_left_c3", 1'b1, 8'h86);
        drive(1'b1, 1'b1, 1'b0, 8'hC3);
        tick();
        chk("b2b_right_c3", 1'b1, 8'h61);
        drive(1'b0, 1'b0, 1'b0, 8'hFF);
        tick();
        chk("b2b_pass_ff", 1'b0, 8'hFF);
        // Mid-stream reset: clears without an edge, first edge after release loads current inputs
        drive(1'b1, 1'b0, 1'b0, 8'h55);
        #2 nreset = 1'b0;
        #1 chk("midreset_async", 1'b0, 8'h00);
        tick();
        chk("midreset_hold", 1'b0, 8'h00);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        chk("post_reset_load", 1'b0, 8'hAA);
        // Input change between edges has no effect until the next edge
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        #1 chk("between_edges", 1'b0, 8'hAA);
        tick();
        chk("right_00_si1", 1'b0, 8'h80);
`ifdef ALU_SHIFTER_PARITY_EN
        drive(1'b0, 1'b0, 1'b0, 8'h03);
        tick();
        chk_p("parity_03", 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h07);
        tick();
        chk_p("parity_07", 1'b0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
